// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute controller.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_IMM
    } state_t;

    localparam logic [1:0] DEST_ACC  = 2'b00;
    localparam logic [1:0] DEST_REG  = 2'b01;
    localparam logic [1:0] DEST_BOTH = 2'b10;
    localparam logic [1:0] DEST_IMM  = 2'b11;

    localparam logic [2:0] SEL_PASS = 3'd0;
    localparam logic [2:0] SEL_AND  = 3'd1;
    localparam logic [2:0] SEL_OR   = 3'd2;
    localparam logic [2:0] SEL_NOT  = 3'd3;
    localparam logic [2:0] SEL_ADD  = 3'd4;
    localparam logic [2:0] SEL_SUB  = 3'd5;
    localparam logic [2:0] SEL_INC  = 3'd6;
    localparam logic [2:0] SEL_DEC  = 3'd7;

    localparam int unsigned SEL_LSB  = 5;
    localparam int unsigned DEST_LSB = 3;
    localparam int unsigned RS_LSB   = 0;

    function automatic logic dest_writes_acc(input logic [1:0] dest);
        return (dest == DEST_ACC) || (dest == DEST_BOTH);
    endfunction

    function automatic logic dest_writes_reg(input logic [1:0] dest);
        return (dest == DEST_REG) || (dest == DEST_BOTH);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction byte valid/ready channel into the execute controller.
interface alu_exec_ctrl_if #(
    parameter int unsigned DW = 8
);
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_exec_regfile.sv
// NREG x DW register file: one combinational read port, one synchronous write port.
module alu_exec_regfile #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-cycle execute controller driving an external combinational ALU.
// Optional flag registers are built when ALU_EXEC_FLAGS_EN is defined.
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_ctrl_if.slave  instr_bus,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [2:0]      alu_sel,
    input  logic [DW-1:0]   alu_out,
    output logic [DW-1:0]   acc,
    output logic            done,
    output logic            zero_flag,
    output logic            neg_flag
);
    localparam int unsigned AW = $clog2(NREG);

    state_t        r_state;
    state_t        w_next;
    logic          w_ready;
    logic          w_retire;
    logic          w_rf_we;
    logic [2:0]    r_sel;
    logic [1:0]    r_dest;
    logic [AW-1:0] r_rs;
    logic [DW-1:0] r_res;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [2:0]    r_alu_sel;
    logic [DW-1:0] r_acc;
    logic          r_done;
    logic [DW-1:0] w_rf_rdata;

    // Ready is a pure state decode so it never depends on instr_valid.
    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_IMM);
    assign w_retire = (r_state == ST_WB) || ((r_state == ST_IMM) && instr_bus.instr_valid);
    assign w_rf_we  = (r_state == ST_WB) && dest_writes_reg(r_dest);
    assign instr_bus.instr_ready = w_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (instr_bus.instr_valid) begin
                    w_next = (instr_bus.instr[DEST_LSB +: 2] == DEST_IMM) ? ST_IMM : ST_READ;
                end
            end
            ST_READ: w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            ST_IMM: begin
                if (instr_bus.instr_valid) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_dest    <= '0;
            r_rs      <= '0;
            r_res     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_retire;
            if ((r_state == ST_IDLE) && instr_bus.instr_valid) begin
                r_sel  <= instr_bus.instr[SEL_LSB +: 3];
                r_dest <= instr_bus.instr[DEST_LSB +: 2];
                r_rs   <= instr_bus.instr[RS_LSB +: AW];
            end
            if (r_state == ST_READ) begin
                r_alu_a   <= r_acc;
                r_alu_b   <= w_rf_rdata;
                r_alu_sel <= r_sel;
            end
            if (r_state == ST_EXEC) begin
                r_res <= alu_out;
            end
            if ((r_state == ST_WB) && dest_writes_acc(r_dest)) begin
                r_acc <= r_res;
            end else if ((r_state == ST_IMM) && instr_bus.instr_valid) begin
                r_acc <= instr_bus.instr;
            end
        end
    end

    alu_exec_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_rf_we),
        .i_waddr (r_rs),
        .i_wdata (r_res),
        .i_raddr (r_rs),
        .o_rdata (w_rf_rdata)
    );

`ifdef ALU_EXEC_FLAGS_EN
    logic [DW-1:0] w_wb_val;
    logic          r_zero;
    logic          r_neg;

    // Flags track the retired value, even when only the register file is written.
    assign w_wb_val = (r_state == ST_IMM) ? instr_bus.instr : r_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_retire) begin
            r_zero <= (w_wb_val == '0);
            r_neg  <= w_wb_val[DW-1];
        end
    end

    assign zero_flag = r_zero;
    assign neg_flag  = r_neg;
`else
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_sel = r_alu_sel;
    assign acc     = r_acc;
    assign done    = r_done;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed plus randomized bench for alu_exec_ctrl with an instruction-level reference model.
module tb_alu_exec_ctrl;
    import alu_exec_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic [7:0] acc;
    logic       done;
    logic       zero_flag;
    logic       neg_flag;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [7:0] m_acc;
    logic [7:0] m_rf [4];
    logic       m_z;
    logic       m_n;

    alu_exec_ctrl_if #(.DW(8)) bus ();

    alu_exec_ctrl #(
        .DW   (8),
        .NREG (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_bus (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .acc       (acc),
        .done      (done),
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            SEL_PASS: return a;
            SEL_AND:  return a & b;
            SEL_OR:   return a | b;
            SEL_NOT:  return ~a;
            SEL_ADD:  return a + b;
            SEL_SUB:  return a - b;
            SEL_INC:  return a + 8'd1;
            default:  return a - 8'd1;
        endcase
    endfunction

    // The ALU itself lives in the bench.
    always_comb alu_out = alu_f(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
`ifdef ALU_EXEC_FLAGS_EN
        chk({tag, "_zero"}, zero_flag, m_z);
        chk({tag, "_neg"}, neg_flag, m_n);
`else
        chk({tag, "_zero"}, zero_flag, 0);
        chk({tag, "_neg"}, neg_flag, 0);
`endif
    endtask

    task automatic retire_model(input logic [7:0] v);
        m_z = (v == 8'h00);
        m_n = v[7];
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after retirement.
    task automatic run_op(input logic [2:0] sel, input logic [1:0] dest, input logic [1:0] rs);
        logic [7:0] res;
        bus.instr_valid = 1'b1;
        bus.instr = {sel, dest, 1'($urandom), rs};
        chk("ready_idle", bus.instr_ready, 1);
        res = alu_f(sel, m_acc, m_rf[rs]);
        @(negedge clk);
        chk("ready_read", bus.instr_ready, 0);
        chk("done_read", done, 0);
        bus.instr_valid = 1'($urandom);
        bus.instr = 8'($urandom);
        @(negedge clk);
        chk("alu_a", alu_a, m_acc);
        chk("alu_b", alu_b, m_rf[rs]);
        chk("alu_sel", alu_sel, sel);
        chk("ready_exec", bus.instr_ready, 0);
        chk("done_exec", done, 0);
        bus.instr_valid = 1'($urandom);
        bus.instr = 8'($urandom);
        @(negedge clk);
        chk("ready_wb", bus.instr_ready, 0);
        chk("done_wb", done, 0);
        chk("acc_wb", acc, m_acc);
        bus.instr_valid = 1'($urandom);
        bus.instr = 8'($urandom);
        @(negedge clk);
        if (dest == DEST_ACC || dest == DEST_BOTH) m_acc = res;
        if (dest == DEST_REG || dest == DEST_BOTH) m_rf[rs] = res;
        retire_model(res);
        chk("done_ret", done, 1);
        chk("acc_ret", acc, m_acc);
        chk("ready_ret", bus.instr_ready, 1);
        chk_flags("ret");
        bus.instr_valid = 1'b0;
    endtask

    task automatic load_imm(input logic [7:0] op, input logic [7:0] val, input int unsigned gap);
        bus.instr_valid = 1'b1;
        bus.instr = {op[7:5], DEST_IMM, op[2:0]};
        chk("ready_idle_li", bus.instr_ready, 1);
        @(negedge clk);
        chk("ready_imm", bus.instr_ready, 1);
        chk("done_imm", done, 0);
        chk("acc_imm", acc, m_acc);
        for (int unsigned g = 0; g < gap; g++) begin
            bus.instr_valid = 1'b0;
            bus.instr = 8'($urandom);
            @(negedge clk);
            chk("ready_imm_wait", bus.instr_ready, 1);
            chk("acc_imm_wait", acc, m_acc);
            chk("done_imm_wait", done, 0);
        end
        bus.instr_valid = 1'b1;
        bus.instr = val;
        @(negedge clk);
        m_acc = val;
        retire_model(val);
        chk("done_li", done, 1);
        chk("acc_li", acc, m_acc);
        chk("ready_li", bus.instr_ready, 1);
        chk_flags("li");
        bus.instr_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 8'h00;
        model_reset();
        #1;
        chk("rst_acc", acc, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk_flags("rst");
        @(negedge clk);
        reset = 1'b0;

        load_imm(8'h18, 8'h05, 0);
        run_op(SEL_ADD, DEST_BOTH, 2'd0);
        run_op(SEL_PASS, DEST_ACC, 2'd0);
        load_imm(8'h18, 8'hFF, 0);
        run_op(SEL_INC, DEST_ACC, 2'd1);
        load_imm(8'h18, 8'h05, 0);
        run_op(SEL_PASS, DEST_REG, 2'd2);
        load_imm(8'h18, 8'h03, 5);
        run_op(SEL_SUB, DEST_REG, 2'd2);
        run_op(SEL_PASS, DEST_ACC, 2'd2);
        run_op(SEL_DEC, DEST_BOTH, 2'd3);

        // Reset while an ADD sits in EXEC.
        load_imm(8'h18, 8'h12, 0);
        bus.instr_valid = 1'b1;
        bus.instr = {SEL_ADD, DEST_ACC, 3'b001};
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_acc", acc, 0);
        chk("midrst_done", done, 0);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_sel", alu_sel, 0);
        chk_flags("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_ready", bus.instr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_done", done, 0);
            chk("postrst_acc", acc, 0);
        end

        for (int i = 0; i < 80; i++) begin
            logic [1:0] d;
            d = 2'($urandom);
            if (d == DEST_IMM) begin
                load_imm(8'($urandom), 8'($urandom), $urandom_range(0, 5));
            end else begin
                run_op(3'($urandom), d, 2'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
